// File: rtl/capture_pkg.sv
// Shared types and constants for the capture sequencer and its trigger combiner.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } cap_state_t;

   localparam int CAP_DEPTH   = 512;
   localparam int NUM_TRIG_SRC = 6;

endpackage

// File: rtl/trig_combine.sv
// Registered AND of all trigger sources, held at zero while the sequencer is not armed.
module trig_combine #(
   parameter int NUM_SRC = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               armed,
   input  logic [NUM_SRC-1:0] src,
   output logic               trig_all
);

   // Gating with armed also flushes any stale agreement left from before arming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trig_all <= 1'b0;
      else        trig_all <= armed & (&src);
   end

endmodule

// File: rtl/capture_sequencer.sv
// Runs one logic-analyzer acquisition: circular pre-trigger capture, trigger latch,
// post-trigger count, then freezes the buffer until readout releases it.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int DEPTH = CAP_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic          smpl_en,
   input  logic          CH1Trig,
   input  logic          CH2Trig,
   input  logic          CH3Trig,
   input  logic          CH4Trig,
   input  logic          CH5Trig,
   input  logic          protTrig,
   input  logic [AW-1:0] trig_pos,
   input  logic          rd_done,
   output logic          armed,
   output logic          triggered,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [AW-1:0] trig_addr,
   output logic          capture_done
);

   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   MAX_TP    = DEPTH_C - 1'b1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ONE       = AW'(1);

   cap_state_t    state, state_nxt;
   logic [AW:0]   smpl_cnt, smpl_cnt_nxt;
   logic [AW-1:0] post_cnt, post_cnt_nxt;
   logic [AW-1:0] waddr_nxt, trig_addr_nxt;
   logic [AW-1:0] tp;
   logic          armed_nxt, triggered_nxt;
   logic          trig_all, fire, post_wr, last_wr;

   trig_combine #(.NUM_SRC(NUM_TRIG_SRC)) u_trig_combine (
      .clk      (clk),
      .rst_n    (rst_n),
      .armed    (armed),
      .src      ({protTrig, CH5Trig, CH4Trig, CH3Trig, CH2Trig, CH1Trig}),
      .trig_all (trig_all)
   );

   // A zero post count still keeps the trigger sample itself; at least one
   // pre-trigger slot is always left in the ring.
   always_comb begin
      tp = trig_pos;
      if (trig_pos == '0)                tp = ONE;
      else if ({1'b0, trig_pos} > MAX_TP) tp = MAX_TP[AW-1:0];
   end

   assign we           = (state == CAPTURE) & smpl_en;
   assign capture_done = (state == DONE);

   assign fire    = (state == CAPTURE) & armed & trig_all & ~triggered;
   assign post_wr = we & (triggered | fire);
   assign last_wr = post_wr & ((post_cnt + ONE) == tp);

   always_comb begin
      state_nxt     = state;
      smpl_cnt_nxt  = smpl_cnt;
      post_cnt_nxt  = post_cnt;
      waddr_nxt     = waddr;
      trig_addr_nxt = trig_addr;
      armed_nxt     = armed;
      triggered_nxt = triggered;
      case (state)
         IDLE: begin
            if (run) begin
               waddr_nxt    = '0;
               smpl_cnt_nxt = '0;
               post_cnt_nxt = '0;
               state_nxt    = CAPTURE;
            end
         end
         CAPTURE: begin
            if (we) begin
               waddr_nxt = (waddr == LAST_ADDR) ? '0 : waddr + ONE;
               if (smpl_cnt != DEPTH_C) smpl_cnt_nxt = smpl_cnt + 1'b1;
            end
            if (fire)    triggered_nxt = 1'b1;
            if (post_wr) post_cnt_nxt  = post_cnt + ONE;
            // Compare against the updated count so armed rises right after
            // the write that completes the pre-trigger history.
            armed_nxt = armed | (smpl_cnt_nxt >= (DEPTH_C - {1'b0, tp}));
            if (last_wr) begin
               trig_addr_nxt = waddr;
               armed_nxt     = 1'b0;
               state_nxt     = DONE;
            end
         end
         DONE: begin
            if (rd_done) begin
               triggered_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         smpl_cnt  <= '0;
         post_cnt  <= '0;
         waddr     <= '0;
         trig_addr <= '0;
         armed     <= 1'b0;
         triggered <= 1'b0;
      end else begin
         state     <= state_nxt;
         smpl_cnt  <= smpl_cnt_nxt;
         post_cnt  <= post_cnt_nxt;
         waddr     <= waddr_nxt;
         trig_addr <= trig_addr_nxt;
         armed     <= armed_nxt;
         triggered <= triggered_nxt;
      end
   end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed spec scenarios plus a randomized run compared cycle by cycle against a
// behavioural acquisition model.
module tb_capture_sequencer;
   import capture_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0;
   logic          smpl_en = 1'b0;
   logic [5:1]    ch = '1;
   logic          prot = 1'b1;
   logic [AW-1:0] trig_pos = '0;
   logic          rd_done = 1'b0;
   logic          armed, triggered, we, capture_done;
   logic [AW-1:0] waddr, trig_addr;

   int n_chk = 0;
   int n_pass = 0;
   int sid = 0;
   int nwe = 0;
   int ram [DEPTH];

   // behavioural model: absolute write count, phase flags
   bit m_cap, m_done, m_arm, m_tall, m_trg;
   int m_nwr, m_post, m_taddr;

   always #5 clk = ~clk;

   capture_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .smpl_en(smpl_en),
      .CH1Trig(ch[1]), .CH2Trig(ch[2]), .CH3Trig(ch[3]), .CH4Trig(ch[4]), .CH5Trig(ch[5]),
      .protTrig(prot), .trig_pos(trig_pos), .rd_done(rd_done),
      .armed(armed), .triggered(triggered), .we(we), .waddr(waddr),
      .trig_addr(trig_addr), .capture_done(capture_done)
   );

   // the capture RAM itself, tagged with the bench's sample id
   always @(posedge clk) begin
      if (we) begin
         ram[waddr] <= sid;
         nwe <= nwe + 1;
      end
   end

   task automatic model_reset();
      m_cap = 0; m_done = 0; m_arm = 0; m_tall = 0; m_trg = 0;
      m_nwr = 0; m_post = 0; m_taddr = 0;
   endtask

   task automatic model_edge();
      bit wr, fire, post, fin;
      int tp, cnt;
      if (!rst_n) begin model_reset(); return; end
      tp   = (trig_pos == 0) ? 1 : int'(trig_pos);
      wr   = m_cap & smpl_en;
      fire = m_cap & m_arm & m_tall & !m_trg;
      post = wr & (m_trg | fire);
      fin  = post && (m_post + 1 == tp);
      m_tall = m_arm & (&ch) & prot;
      if (m_cap) begin
         if (wr) m_nwr++;
         if (post) m_post++;
         if (fire) m_trg = 1;
         cnt = (m_nwr > DEPTH) ? DEPTH : m_nwr;
         m_arm = m_arm | (cnt >= DEPTH - tp);
         if (fin) begin
            m_taddr = (m_nwr - 1) % DEPTH;
            m_arm = 0; m_cap = 0; m_done = 1;
         end
      end else if (m_done) begin
         if (rd_done) begin m_done = 0; m_trg = 0; end
      end else if (run) begin
         m_cap = 1; m_nwr = 0; m_post = 0;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input bit se);
      smpl_en = se;
      if (se) sid++;
      #1;
      tick();
   endtask

   task automatic start_run();
      run = 1'b1;
      step(1'b0);
      run = 1'b0;
      sid = 0;
   endtask

   task automatic release_buf();
      rd_done = 1'b1;
      step(1'b0);
      rd_done = 1'b0;
   endtask

   task automatic test_reset();
      n_chk++;
      if ({armed, triggered, we, capture_done, waddr, trig_addr} !== '0 || dut.state !== IDLE)
         $display("FAIL reset_hold: outs=%b state=%0d want all 0 / IDLE",
                  {armed, triggered, we, capture_done, waddr, trig_addr}, dut.state);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      model_reset();
      trig_pos = 4; ch = '1; prot = 1'b1;
      start_run();
      for (int c = 0; c < 28; c++) step(c % 2 == 0);
      n_chk++;
      if (!(armed && triggered && waddr != 0))
         $display("FAIL reset_precond: armed=%b triggered=%b waddr=%0d want 1/1/nonzero",
                  armed, triggered, waddr);
      else n_pass++;
      smpl_en = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_chk++;
      if ({armed, triggered, we, capture_done, waddr, trig_addr} !== '0 || dut.state !== IDLE)
         $display("FAIL reset_mid_capture: outs=%b state=%0d want all 0 / IDLE",
                  {armed, triggered, we, capture_done, waddr, trig_addr}, dut.state);
      else n_pass++;
      smpl_en = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int base, arm_at, arm_cyc, trg_cyc;
      trig_pos = 4; ch = '1; prot = 1'b1;
      start_run();
      base = nwe; arm_at = -1; arm_cyc = -1; trg_cyc = -1;
      for (int c = 0; c < 200 && !capture_done; c++) begin
         if (armed && arm_at < 0) begin arm_at = nwe - base; arm_cyc = c; end
         if (triggered && trg_cyc < 0) trg_cyc = c;
         step(c % 2 == 0);
      end
      n_chk++;
      if (arm_at != 12) $display("FAIL basic_armed_at: samples=%0d want 12", arm_at);
      else n_pass++;
      n_chk++;
      if (trg_cyc - arm_cyc != 2)
         $display("FAIL basic_trig_latency: cycles=%0d want 2", trg_cyc - arm_cyc);
      else n_pass++;
      n_chk++;
      if (!capture_done || armed || !triggered || nwe - base != 16)
         $display("FAIL basic_done: done=%b armed=%b trig=%b writes=%0d want 1/0/1/16",
                  capture_done, armed, triggered, nwe - base);
      else n_pass++;
      n_chk++;
      if (trig_addr !== 4'd15) $display("FAIL basic_trig_addr: got %0d want 15", trig_addr);
      else n_pass++;
      release_buf();
      n_chk++;
      if (capture_done || triggered || dut.state !== IDLE)
         $display("FAIL basic_release: done=%b trig=%b state=%0d want 0/0/IDLE",
                  capture_done, triggered, dut.state);
      else n_pass++;
   endtask

   task automatic test_early_pulse();
      int base, arm_age, p, snap, trg_cyc;
      bit early;
      trig_pos = 4; ch = 5'b11011; prot = 1'b1;
      start_run();
      base = nwe; arm_age = 0; p = -10; snap = 0; trg_cyc = -1; early = 0;
      for (int c = 0; c < 200 && !capture_done; c++) begin
         ch[3] = 1'b0;
         if (!armed && !early && nwe - base == 5) begin ch[3] = 1'b1; early = 1; end
         if (armed) arm_age++;
         if (arm_age == 3 && p < 0) begin
            p = c;
            ch[3] = 1'b1;
            n_chk++;
            if (triggered !== 1'b0) $display("FAIL early_pulse_ignored: triggered=%b want 0", triggered);
            else n_pass++;
         end
         if (c == p + 1) snap = nwe;
         if (triggered && trg_cyc < 0) trg_cyc = c;
         step(c % 2 == 0);
      end
      ch[3] = 1'b1;
      n_chk++;
      if (trg_cyc != p + 2) $display("FAIL late_pulse_latency: cyc=%0d want %0d", trg_cyc, p + 2);
      else n_pass++;
      n_chk++;
      if (!capture_done || nwe - snap != 4)
         $display("FAIL late_pulse_posts: done=%b post_writes=%0d want 1/4", capture_done, nwe - snap);
      else n_pass++;
      release_buf();
   endtask

   task automatic test_tp_zero();
      int base, arm_at, trg_cyc, done_cyc;
      trig_pos = 0; ch = '1; prot = 1'b1;
      start_run();
      base = nwe; arm_at = -1; trg_cyc = -1; done_cyc = -1;
      for (int c = 0; c < 200 && !capture_done; c++) begin
         if (armed && arm_at < 0) arm_at = nwe - base;
         step(c % 2 == 0);
         if (triggered && trg_cyc < 0) trg_cyc = c;
         if (capture_done && done_cyc < 0) done_cyc = c;
      end
      n_chk++;
      if (arm_at != 15) $display("FAIL tp0_armed_at: samples=%0d want 15", arm_at);
      else n_pass++;
      n_chk++;
      if (done_cyc < 0 || done_cyc != trg_cyc)
         $display("FAIL tp0_done_on_trigger: trig_cyc=%0d done_cyc=%0d want equal", trg_cyc, done_cyc);
      else n_pass++;
      n_chk++;
      if (trig_addr !== AW'((nwe - base - 1) % DEPTH) || nwe - base != 16)
         $display("FAIL tp0_trig_addr: got %0d writes=%0d want 15 / 16", trig_addr, nwe - base);
      else n_pass++;
      release_buf();
   endtask

   task automatic test_holdoff();
      int base, k;
      bit released;
      trig_pos = 4; ch = '1; prot = 1'b0;
      start_run();
      base = nwe; released = 0;
      for (int c = 0; c < 400 && !capture_done; c++) begin
         if (!released && nwe - base == 40) begin
            released = 1;
            prot = 1'b1;
            n_chk++;
            if (waddr !== 4'd8 || dut.smpl_cnt !== 5'd16 || triggered)
               $display("FAIL holdoff_wrap: waddr=%0d smpl_cnt=%0d trig=%b want 8/16/0",
                        waddr, dut.smpl_cnt, triggered);
            else n_pass++;
         end
         step(c % 2 == 0);
      end
      k = nwe - base;
      n_chk++;
      if (!capture_done || k != 44 || trig_addr !== 4'd11)
         $display("FAIL holdoff_done: done=%b writes=%0d trig_addr=%0d want 1/44/11",
                  capture_done, k, trig_addr);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         n_chk++;
         if (ram[(int'(trig_addr) + 1 + i) % DEPTH] != k - DEPTH + 1 + i)
            $display("FAIL holdoff_buffer[%0d]: got %0d want %0d", i,
                     ram[(int'(trig_addr) + 1 + i) % DEPTH], k - DEPTH + 1 + i);
         else n_pass++;
      end
   endtask

   task automatic test_done_hold();
      int wa, base;
      wa = int'(waddr); base = nwe;
      for (int c = 0; c < 6; c++) begin
         run = (c % 3 == 0);
         smpl_en = 1'b1;
         #1;
         n_chk++;
         if (we || int'(waddr) != wa || !capture_done)
            $display("FAIL done_frozen: we=%b waddr=%0d done=%b want 0/%0d/1", we, waddr, capture_done, wa);
         else n_pass++;
         tick();
      end
      run = 1'b0;
      n_chk++;
      if (nwe != base) $display("FAIL done_no_writes: writes=%0d want 0", nwe - base);
      else n_pass++;
      release_buf();
      start_run();
      smpl_en = 1'b1;
      #1;
      n_chk++;
      if (!we || waddr !== '0 || capture_done)
         $display("FAIL restart: we=%b waddr=%0d done=%b want 1/0/0", we, waddr, capture_done);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      logic [11:0] got, exp;
      rst_n = 1'b0;
      smpl_en = 1'b0; run = 1'b0; rd_done = 1'b0;
      #1;
      model_reset();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         if (!m_cap && !m_done) trig_pos = AW'($urandom_range(0, DEPTH - 1));
         run     = ($urandom_range(0, 7) == 0);
         rd_done = ($urandom_range(0, 5) == 0);
         smpl_en = $urandom_range(0, 1);
         for (int i = 1; i <= 5; i++) ch[i] = ($urandom_range(0, 9) != 0);
         prot = ($urandom_range(0, 9) != 0);
         #1;
         got = {armed, triggered, we, capture_done, waddr, trig_addr};
         exp = {m_arm, m_trg, m_cap & smpl_en, m_done, AW'(m_nwr % DEPTH), AW'(m_taddr)};
         n_chk++;
         if (got !== exp)
            $display("FAIL random_cycle%0d: {arm,trg,we,done,waddr,taddr} got %b want %b", c, got, exp);
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      model_reset();
      #2;
      test_reset();
      test_basic();
      test_early_pulse();
      test_tp_zero();
      test_holdoff();
      test_done_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
